id_stage: RTL

- Instruction-decode stage sitting directly downstream of the fetch stage in the MIPS pipeline.
- Latches the fetched instruction and its PC+4 into an IF/ID pipeline register with stall and flush control.
- Decodes the instruction fields and reads a 32x32 register file that is written by the writeback stage.
- Detects load-use hazards against the EX stage and raises a stall back to fetch.

---
 rtl/id_stage_pkg.sv | 57 +++++
 rtl/id_regfile.sv | 82 ++++++++
 rtl/id_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the MIPS instruction-decode stage: default sizes,
// opcode constants, instruction field positions and small decode helpers.
package id_stage_pkg;

   // Default architectural sizes
   localparam int DEF_NREG = 32;
   localparam int DEF_XLEN = 32;
   localparam int REG_AW   = 5;

   // Opcodes the decode stage treats specially
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   // Instruction field bit positions
   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Immediate extension: logical ops zero-extend, lui shifts up, all else sign-extend
   function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
      logic [31:0] res;
      case (op)
         OP_ANDI, OP_ORI, OP_XORI: res = {16'h0000, imm};
         OP_LUI:                   res = {imm, 16'h0000};
         default:                  res = {{16{imm[15]}}, imm};
      endcase
      return res;
   endfunction

   // Instructions that read rt as a source operand (R-type, branches, store)
   function automatic logic op_uses_rt(input logic [5:0] op);
      logic res;
      case (op)
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: res = 1'b1;
         default:                         res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file for the decode stage: synchronous reset and write,
// two asynchronous read ports, register 0 hardwired to zero.
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback onto the read ports.
module id_regfile
   import id_stage_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int XLEN = DEF_XLEN,
   parameter int AW   = REG_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   ra_addr,
   input  logic [AW-1:0]   rb_addr,
   output logic [XLEN-1:0] ra_data,
   output logic [XLEN-1:0] rb_data
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic            wr_en;

   // A write to register 0 is dropped so that entry never leaves zero
   assign wr_en = we & (waddr != {AW{1'b0}});

   // Next-state of the storage array: apply the single write port
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[waddr] = wdata;
      end else begin
         regs_d = regs_q;
      end
   end

   // Storage update with synchronous clear of every entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {XLEN{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read port A: register 0 reads zero, optional same-cycle forwarding
   always_comb begin
      ra_data = {XLEN{1'b0}};
      if (ra_addr == {AW{1'b0}}) begin
         ra_data = {XLEN{1'b0}};
      end
`ifdef WB_BYPASS_EN
      else if (wr_en && (waddr == ra_addr)) begin
         ra_data = wdata;
      end
`endif
      else begin
         ra_data = regs_q[ra_addr];
      end
   end

   // Read port B: same behaviour as port A
   always_comb begin
      rb_data = {XLEN{1'b0}};
      if (rb_addr == {AW{1'b0}}) begin
         rb_data = {XLEN{1'b0}};
      end
`ifdef WB_BYPASS_EN
      else if (wr_en && (waddr == rb_addr)) begin
         rb_data = wdata;
      end
`endif
      else begin
         rb_data = regs_q[rb_addr];
      end
   end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID pipeline register with flush/stall,
// field decode, immediate extension, register-file read and load-use hazard
// detection against EX. Optional macro WB_BYPASS_EN enables writeback
// forwarding inside the register file.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int XLEN = DEF_XLEN
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [31:0]     Ins,
   input  logic [31:0]     nextPC,
   input  logic            flush,
   input  logic            ex_MemRead,
   input  logic [4:0]      ex_rt,
   input  logic            wb_WE,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall,
   output logic            id_valid,
   output logic [31:0]     id_PC4,
   output logic [5:0]      opcode,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [4:0]      shamt,
   output logic [5:0]      funct,
   output logic [XLEN-1:0] rs_data,
   output logic [XLEN-1:0] rt_data,
   output logic [31:0]     imm_ext
);

   logic [31:0] ifid_ins_q, ifid_ins_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_v_q,   ifid_v_d;
   logic        hz_rs;
   logic        hz_rt;

   // IF/ID next state: flush kills, stall holds, otherwise accept from fetch
   always_comb begin
      ifid_ins_d = ifid_ins_q;
      ifid_pc4_d = ifid_pc4_q;
      ifid_v_d   = ifid_v_q;
      if (flush) begin
         ifid_ins_d = 32'h0000_0000;
         ifid_pc4_d = 32'h0000_0000;
         ifid_v_d   = 1'b0;
      end else if (stall) begin
         ifid_ins_d = ifid_ins_q;
         ifid_pc4_d = ifid_pc4_q;
         ifid_v_d   = ifid_v_q;
      end else begin
         ifid_ins_d = Ins;
         ifid_pc4_d = nextPC;
         ifid_v_d   = 1'b1;
      end
   end

   // IF/ID pipeline register with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         ifid_ins_q <= 32'h0000_0000;
         ifid_pc4_q <= 32'h0000_0000;
         ifid_v_q   <= 1'b0;
      end else begin
         ifid_ins_q <= ifid_ins_d;
         ifid_pc4_q <= ifid_pc4_d;
         ifid_v_q   <= ifid_v_d;
      end
   end

   // Field decode straight from the latched instruction
   assign opcode  = ifid_ins_q[OPC_HI:OPC_LO];
   assign rs      = ifid_ins_q[RS_HI:RS_LO];
   assign rt      = ifid_ins_q[RT_HI:RT_LO];
   assign rd      = ifid_ins_q[RD_HI:RD_LO];
   assign shamt   = ifid_ins_q[SH_HI:SH_LO];
   assign funct   = ifid_ins_q[FN_HI:FN_LO];
   assign imm_ext = ext_imm(ifid_ins_q[OPC_HI:OPC_LO], ifid_ins_q[IMM_HI:IMM_LO]);
   assign id_PC4  = ifid_pc4_q;

   // Load-use hazard: the load in EX targets a register this instruction reads.
   // EX sees a bubble next cycle, so the stall clears by itself after one cycle.
   always_comb begin
      hz_rs = (ex_rt == rs);
      hz_rt = op_uses_rt(opcode) & (ex_rt == rt);
      stall = ifid_v_q & ex_MemRead & (ex_rt != 5'd0) & (hz_rs | hz_rt);
   end

   // A stalled cycle is presented downstream as a bubble
   assign id_valid = ifid_v_q & ~stall;

   id_regfile #(
      .NREG (NREG),
      .XLEN (XLEN),
      .AW   (REG_AW)
   ) u_regfile (
      .clk     (CLK),
      .rst     (RST),
      .we      (wb_WE),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .ra_addr (rs),
      .rb_addr (rt),
      .ra_data (rs_data),
      .rb_data (rt_data)
   );

endmodule
